// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: ROM port, redirect/halt controls and decode handshake.
// DUT side uses modport master; the environment uses modport slave.
interface inst_fetch_if;
  logic [11:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        ins_ready;
  logic        ins_valid;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic [1:0]  fetch_state;

  modport master (
    output rom_addr, ins_valid, ins_data, ins_pc, fetch_state,
    input  rom_data, redirect, redirect_pc, halt, ins_ready
  );

  modport slave (
    input  rom_addr, ins_valid, ins_data, ins_pc, fetch_state,
    output rom_data, redirect, redirect_pc, halt, ins_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, ROM addressing, 2-entry queue to decode.
// Optional FETCH_JUMP_PREDECODE_EN follows J-type words without a redirect.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          QDEPTH   = 2
) (
  input logic          clk,
  input logic          rstd,
  inst_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  localparam logic [1:0] FULL = 2'(QDEPTH);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  entry_t      q_q [2];
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        valid;
  logic        pop;
  logic        push;
  logic [31:0] seq_pc;
  logic        unused_lsb;

  assign unused_lsb = ^bus.redirect_pc[1:0];

  assign valid = (cnt_q != 2'd0);
  // A pop racing a redirect belongs to the flushed stream.
  assign pop   = valid && bus.ins_ready && !bus.redirect;
  assign push  = (state_q == RUN) && !bus.halt && !bus.redirect &&
                 ((cnt_q != FULL) || pop);

`ifdef FETCH_JUMP_PREDECODE_EN
  logic is_j;
  assign is_j   = (bus.rom_data[31:26] == 6'b000010);
  assign seq_pc = is_j ? {pc_q[31:28], bus.rom_data[25:0], 2'b00}
                       : pc_q + 32'd4;
`else
  assign seq_pc = pc_q + 32'd4;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (bus.halt) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (bus.redirect) begin
      pc_d  = {bus.redirect_pc[31:2], 2'b00};
      cnt_d = 2'd0;
      wr_d  = 1'b0;
      rd_d  = 1'b0;
    end else begin
      if (push) begin
        pc_d = seq_pc;
        wr_d = ~wr_q;
      end
      if (pop) rd_d = ~rd_q;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      cnt_q   <= 2'd0;
      for (int i = 0; i < 2; i++) q_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      if (push) q_q[wr_q] <= '{data: bus.rom_data, pc: pc_q};
    end
  end

  assign bus.rom_addr    = pc_q[11:0];
  assign bus.ins_valid   = valid;
  assign bus.ins_data    = valid ? q_q[rd_q].data : 32'd0;
  assign bus.ins_pc      = valid ? q_q[rd_q].pc : 32'd0;
  assign bus.fetch_state = state_q;

endmodule
